age_ordered_rs: RTL and testbench
=================================

AGE_ORDERED_RS -- requirements
Module: age_ordered_rs

Interface
REQ-001 SHALL have parameter RS_ENTRIES, default 8: number of entries, any value >= 2.
REQ-002 SHALL have parameter ROB_ADDR_WIDTH, default 4: ROB tag width.
REQ-003 SHALL have parameter OP_WIDTH, default 4: opcode width.
REQ-004 SHALL have parameter CDB_PORTS, default 2: number of broadcast buses.
REQ-005 SHALL have the following ports. Widths use RS_CNT_W = $clog2(RS_ENTRIES+1).
- clock  in  1: sole clock; one clock domain, rising edge.
- reset  in  1: synchronous, active-high.
- flush  in  1: discard all entries.
- dispatch_valid  in  1: dispatch request.
- dispatch_ready  out  1: an entry is free.
- dispatch_op  in  OP_WIDTH: opcode.
- dispatch_src1_value / dispatch_src2_value  in  32: operand values.
- dispatch_src1_ready / dispatch_src2_ready  in  1: operand valid.
- dispatch_src1_tag / dispatch_src2_tag  in  ROB_ADDR_WIDTH: producer tags.
- dispatch_dest_tag  in  ROB_ADDR_WIDTH: destination tag.
- cdb_valid  in  CDB_PORTS: per-bus valid.
- cdb_tag  in  CDB_PORTS x ROB_ADDR_WIDTH: per-bus tag.
- cdb_data  in  CDB_PORTS x 32: per-bus data.
- issue_valid  out  1: oldest ready entry presented.
- issue_ready  in  1: execution unit accepts.
- issue_op  out  OP_WIDTH: issued opcode.
- issue_src1_value / issue_src2_value  out  32: issued operands.
- issue_dest_tag  out  ROB_ADDR_WIDTH: issued destination tag.
- rs_count  out  RS_CNT_W: occupied entries.

Function
REQ-006 SHALL assert dispatch_ready = (rs_count < RS_ENTRIES), registered-state only; an entry freed by issue in the same cycle does not raise it.
REQ-007 SHALL write a dispatch into the lowest-index free entry when dispatch_valid && dispatch_ready && !flush; the entry becomes visible next cycle.
REQ-008 SHALL wake an operand when a waiting source matches any valid cdb_tag, capturing cdb_data; on multiple matches the lowest port index wins.
REQ-009 SHALL apply REQ-008 to the dispatching instruction in the same cycle (dispatch-cycle bypass).
REQ-010 SHALL drive issue_valid combinationally from registered state: at least one valid entry with both operands ready, and !flush. issue_valid SHALL NOT depend on issue_ready.
REQ-011 SHALL select the oldest ready entry by dispatch order using an RS_ENTRIES x RS_ENTRIES age matrix; slot index is irrelevant to selection.
REQ-012 SHALL hold issue_* stable while issue_valid && !issue_ready unless an older entry becomes ready.
REQ-013 SHALL free the selected entry on issue_valid && issue_ready; latency from last-operand wakeup to issue_valid is 1 cycle.
REQ-014 SHALL allow simultaneous dispatch, issue and wakeups in one cycle. rs_count SHALL update by +dispatch -issue.
REQ-015 SHALL on flush: ignore dispatch, force issue_valid low, and clear all entries, the age matrix and rs_count next cycle.
REQ-016 SHALL ignore CDB matches on invalid entries and on already-ready operands.

Reset
REQ-017 SHALL on reset clear all entry valid bits and the age matrix, set rs_count=0, and drive issue_valid=0 and dispatch_ready=1 the cycle after release. Payload fields need not reset.
REQ-018 SHALL give reset priority over flush, dispatch and issue.

Configuration
REQ-019 SHALL, when RS_PERF_CNT_EN is defined, add outputs perf_issue_cnt[31:0] (issue handshakes) and perf_stall_cnt[31:0] (cycles with dispatch_valid && !dispatch_ready). Both clear on reset, are unaffected by flush, and wrap modulo 2^32.
REQ-020 SHALL, without RS_PERF_CNT_EN, have neither these ports nor their logic.

Structure
REQ-021 SHALL take rob_tag_t, the rs_entry_t struct and the default widths from shared package ooo_pkg.
REQ-022 SHALL implement the age matrix and oldest-ready selection in sub-module rs_age_matrix (inputs alloc one-hot, free one-hot, clear, req vector; output grant one-hot).

Verification
REQ-023 Dispatch op=3 with srcs 5/7 both ready, issue_ready=1 -> issue_valid next cycle with values 5/7, then rs_count returns to 0.
REQ-024 Dispatch A (src1 waits on tag 2) into slot 0, then B (both ready) into slot 1; cdb tag 2 data 0x99 -> B issues first; A issues with src1=0x99 one cycle after the wakeup.
REQ-025 Fill 8 entries -> dispatch_ready=0 and perf_stall_cnt increments per stalled cycle; one issue -> dispatch_ready=1 the next cycle.
REQ-026 Dispatch with src2 tag 6 while cdb port 1 broadcasts tag 6 data 0x1234 -> entry is ready next cycle with src2=0x1234.
REQ-027 Occupied RS with issue_valid=1, assert flush together with dispatch_valid -> issue_valid=0 that cycle, and rs_count=0 next cycle.
REQ-028 Free slot 0 after slots 0-3 were filled, then dispatch D into slot 0 with slots 1-3 ready -> slot 1 (oldest) issues before D.

Source files
------------

// File: rtl/ooo_pkg.sv
// rtl/ooo_pkg.sv - shared widths and entry types for the out-of-order core
package ooo_pkg;

  localparam int RS_ENTRIES_DEF     = 8;
  localparam int ROB_ADDR_WIDTH_DEF = 4;
  localparam int OP_WIDTH_DEF       = 4;
  localparam int CDB_PORTS_DEF      = 2;
  localparam int DATA_WIDTH         = 32;

  typedef logic [ROB_ADDR_WIDTH_DEF-1:0] rob_tag_t;
  typedef logic [OP_WIDTH_DEF-1:0]       op_t;
  typedef logic [DATA_WIDTH-1:0]         data_t;

  // One source operand: either holds its value or waits on a producer tag
  typedef struct packed {
    logic     ready;
    rob_tag_t tag;
    data_t    value;
  } rs_src_t;

  typedef struct packed {
    logic     valid;
    op_t      op;
    rs_src_t  src1;
    rs_src_t  src2;
    rob_tag_t dest_tag;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_matrix.sv
// rtl/rs_age_matrix.sv - dispatch-order age matrix with oldest-ready grant
module rs_age_matrix
  import ooo_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic [ENTRIES-1:0] alloc,
  input  logic [ENTRIES-1:0] free,
  input  logic [ENTRIES-1:0] req,
  output logic [ENTRIES-1:0] grant
);

  // older[i][j] set means slot i was dispatched before slot j
  logic [ENTRIES-1:0][ENTRIES-1:0] older;
  logic [ENTRIES-1:0]              blocked;

  // A new slot is younger than every other slot; freed slots drop their relations
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      older <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        for (int j = 0; j < ENTRIES; j++) begin
          if (alloc[j] && (i != j)) begin
            older[i][j] <= 1'b1;
          end else if (alloc[i]) begin
            older[i][j] <= 1'b0;
          end else if (free[i] || free[j]) begin
            older[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  // A requester is blocked when any older slot is also requesting
  always_comb begin
    blocked = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      for (int j = 0; j < ENTRIES; j++) begin
        if ((j != i) && req[j] && older[j][i]) begin
          blocked[i] = 1'b1;
        end
      end
    end
  end

  assign grant = req & ~blocked;

endmodule

// File: rtl/age_ordered_rs.sv
// rtl/age_ordered_rs.sv - age-ordered reservation station; RS_PERF_CNT_EN adds perf counters
module age_ordered_rs
  import ooo_pkg::*;
#(
  parameter int RS_ENTRIES     = RS_ENTRIES_DEF,
  parameter int ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEF,
  parameter int OP_WIDTH       = OP_WIDTH_DEF,
  parameter int CDB_PORTS      = CDB_PORTS_DEF
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     flush,
  input  logic                                     dispatch_valid,
  output logic                                     dispatch_ready,
  input  logic [OP_WIDTH-1:0]                      dispatch_op,
  input  logic [31:0]                              dispatch_src1_value,
  input  logic [31:0]                              dispatch_src2_value,
  input  logic                                     dispatch_src1_ready,
  input  logic                                     dispatch_src2_ready,
  input  logic [ROB_ADDR_WIDTH-1:0]                dispatch_src1_tag,
  input  logic [ROB_ADDR_WIDTH-1:0]                dispatch_src2_tag,
  input  logic [ROB_ADDR_WIDTH-1:0]                dispatch_dest_tag,
  input  logic [CDB_PORTS-1:0]                     cdb_valid,
  input  logic [CDB_PORTS-1:0][ROB_ADDR_WIDTH-1:0] cdb_tag,
  input  logic [CDB_PORTS-1:0][31:0]               cdb_data,
  output logic                                     issue_valid,
  input  logic                                     issue_ready,
  output logic [OP_WIDTH-1:0]                      issue_op,
  output logic [31:0]                              issue_src1_value,
  output logic [31:0]                              issue_src2_value,
  output logic [ROB_ADDR_WIDTH-1:0]                issue_dest_tag,
  output logic [$clog2(RS_ENTRIES+1)-1:0]          rs_count
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0]                              perf_issue_cnt,
  output logic [31:0]                              perf_stall_cnt
`endif
);

  localparam int RS_CNT_W = $clog2(RS_ENTRIES+1);

  rs_entry_t             entries [RS_ENTRIES];
  rs_entry_t             new_entry;
  rs_src_t               src1_in;
  rs_src_t               src2_in;
  logic [RS_ENTRIES-1:0] valid_vec;
  logic [RS_ENTRIES-1:0] req_vec;
  logic [RS_ENTRIES-1:0] grant;
  logic [RS_ENTRIES-1:0] free_slot;
  logic [RS_ENTRIES-1:0] alloc_oh;
  logic [RS_ENTRIES-1:0] free_oh;
  logic                  slot_found;
  logic                  do_dispatch;
  logic                  do_issue;

  // Capture a broadcast result for a waiting operand; the lowest bus wins ties
  function automatic rs_src_t wake(input rs_src_t s);
    rs_src_t r;
    r = s;
    if (!s.ready) begin
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (cdb_valid[p] && (rob_tag_t'(cdb_tag[p]) == s.tag)) begin
          r.ready = 1'b1;
          r.value = cdb_data[p];
        end
      end
    end
    return r;
  endfunction

  assign dispatch_ready = (rs_count < RS_CNT_W'(RS_ENTRIES));
  assign do_dispatch    = dispatch_valid && dispatch_ready && !flush;
  assign issue_valid    = (|req_vec) && !flush;
  assign do_issue       = issue_valid && issue_ready;
  assign free_oh        = grant & {RS_ENTRIES{do_issue}};
  assign alloc_oh       = free_slot & {RS_ENTRIES{do_dispatch}};

  // Occupancy and readiness per slot from registered state only
  always_comb begin
    valid_vec = '0;
    req_vec   = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      valid_vec[i] = entries[i].valid;
      req_vec[i]   = entries[i].valid && entries[i].src1.ready && entries[i].src2.ready;
    end
  end

  // Lowest-index empty slot receives the next dispatch
  always_comb begin
    free_slot  = '0;
    slot_found = 1'b0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (!valid_vec[i] && !slot_found) begin
        free_slot[i] = 1'b1;
        slot_found   = 1'b1;
      end
    end
  end

  // Build the incoming entry, letting same-cycle broadcasts wake its operands
  always_comb begin
    src1_in.ready      = dispatch_src1_ready;
    src1_in.tag        = rob_tag_t'(dispatch_src1_tag);
    src1_in.value      = dispatch_src1_value;
    src2_in.ready      = dispatch_src2_ready;
    src2_in.tag        = rob_tag_t'(dispatch_src2_tag);
    src2_in.value      = dispatch_src2_value;
    new_entry.valid    = 1'b1;
    new_entry.op       = op_t'(dispatch_op);
    new_entry.src1     = wake(src1_in);
    new_entry.src2     = wake(src2_in);
    new_entry.dest_tag = rob_tag_t'(dispatch_dest_tag);
  end

  // Entry storage: allocate, free on issue, and wake waiting operands
  always_ff @(posedge clock) begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (reset || flush) begin
        entries[i].valid <= 1'b0;
      end else if (alloc_oh[i]) begin
        entries[i] <= new_entry;
      end else begin
        if (free_oh[i]) begin
          entries[i].valid <= 1'b0;
        end
        if (entries[i].valid) begin
          entries[i].src1 <= wake(entries[i].src1);
          entries[i].src2 <= wake(entries[i].src2);
        end
      end
    end
  end

  // Occupancy count tracks dispatches in and issues out
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rs_count <= '0;
    end else begin
      rs_count <= rs_count + RS_CNT_W'(do_dispatch) - RS_CNT_W'(do_issue);
    end
  end

  rs_age_matrix #(
    .ENTRIES (RS_ENTRIES)
  ) u_age (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .alloc (alloc_oh),
    .free  (free_oh),
    .req   (req_vec),
    .grant (grant)
  );

  // Present the granted (oldest ready) entry on the issue port
  always_comb begin
    issue_op         = '0;
    issue_src1_value = '0;
    issue_src2_value = '0;
    issue_dest_tag   = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (grant[i]) begin
        issue_op         = OP_WIDTH'(entries[i].op);
        issue_src1_value = entries[i].src1.value;
        issue_src2_value = entries[i].src2.value;
        issue_dest_tag   = ROB_ADDR_WIDTH'(entries[i].dest_tag);
      end
    end
  end

`ifdef RS_PERF_CNT_EN
  // Issue handshakes and dispatch stall cycles; flush does not touch them
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (do_issue) begin
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      end
      if (dispatch_valid && !dispatch_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_age_ordered_rs.sv
// tb/tb_age_ordered_rs.sv - bench for age_ordered_rs with queue-based reference model
module tb_age_ordered_rs;

  logic             clock;
  logic             reset;
  logic             flush;
  logic             dispatch_valid;
  logic             dispatch_ready;
  logic [3:0]       dispatch_op;
  logic [31:0]      dispatch_src1_value;
  logic [31:0]      dispatch_src2_value;
  logic             dispatch_src1_ready;
  logic             dispatch_src2_ready;
  logic [3:0]       dispatch_src1_tag;
  logic [3:0]       dispatch_src2_tag;
  logic [3:0]       dispatch_dest_tag;
  logic [1:0]       cdb_valid;
  logic [1:0][3:0]  cdb_tag;
  logic [1:0][31:0] cdb_data;
  logic             issue_valid;
  logic             issue_ready;
  logic [3:0]       issue_op;
  logic [31:0]      issue_src1_value;
  logic [31:0]      issue_src2_value;
  logic [3:0]       issue_dest_tag;
  logic [3:0]       rs_count;
`ifdef RS_PERF_CNT_EN
  logic [31:0]      perf_issue_cnt;
  logic [31:0]      perf_stall_cnt;
`endif

  age_ordered_rs dut (
    .clock               (clock),
    .reset               (reset),
    .flush               (flush),
    .dispatch_valid      (dispatch_valid),
    .dispatch_ready      (dispatch_ready),
    .dispatch_op         (dispatch_op),
    .dispatch_src1_value (dispatch_src1_value),
    .dispatch_src2_value (dispatch_src2_value),
    .dispatch_src1_ready (dispatch_src1_ready),
    .dispatch_src2_ready (dispatch_src2_ready),
    .dispatch_src1_tag   (dispatch_src1_tag),
    .dispatch_src2_tag   (dispatch_src2_tag),
    .dispatch_dest_tag   (dispatch_dest_tag),
    .cdb_valid           (cdb_valid),
    .cdb_tag             (cdb_tag),
    .cdb_data            (cdb_data),
    .issue_valid         (issue_valid),
    .issue_ready         (issue_ready),
    .issue_op            (issue_op),
    .issue_src1_value    (issue_src1_value),
    .issue_src2_value    (issue_src2_value),
    .issue_dest_tag      (issue_dest_tag),
    .rs_count            (rs_count)
`ifdef RS_PERF_CNT_EN
    ,
    .perf_issue_cnt      (perf_issue_cnt),
    .perf_stall_cnt      (perf_stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instructions kept in dispatch order, oldest first
  typedef struct {
    logic [3:0]  op;
    logic [31:0] v1;
    bit          r1;
    logic [3:0]  t1;
    logic [31:0] v2;
    bit          r2;
    logic [3:0]  t2;
    logic [3:0]  dest;
  } m_entry_t;

  m_entry_t mq[$];
  int       m_issues = 0;
  int       m_stalls = 0;
  int       m_k;
  int       m_n0;
  m_entry_t m_new;
  int       c_k;
  bit       c_iv;

  function automatic m_entry_t m_wake(input m_entry_t e);
    m_entry_t r;
    r = e;
    if (!r.r1) begin
      for (int p = 0; p < 2; p++) begin
        if (cdb_valid[p] && cdb_tag[p] == r.t1) begin
          r.r1 = 1'b1;
          r.v1 = cdb_data[p];
          break;
        end
      end
    end
    if (!r.r2) begin
      for (int p = 0; p < 2; p++) begin
        if (cdb_valid[p] && cdb_tag[p] == r.t2) begin
          r.r2 = 1'b1;
          r.v2 = cdb_data[p];
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic int m_oldest();
    foreach (mq[i]) begin
      if (mq[i].r1 && mq[i].r2) return i;
    end
    return -1;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      m_issues = 0;
      m_stalls = 0;
    end else begin
      m_n0 = mq.size();
      if (dispatch_valid && m_n0 >= 8) m_stalls++;
      if (flush) begin
        mq.delete();
      end else begin
        m_k = m_oldest();
        if (m_k >= 0 && issue_ready) begin
          mq.delete(m_k);
          m_issues++;
        end
        foreach (mq[i]) mq[i] = m_wake(mq[i]);
        if (dispatch_valid && m_n0 < 8) begin
          m_new.op   = dispatch_op;
          m_new.v1   = dispatch_src1_value;
          m_new.r1   = dispatch_src1_ready;
          m_new.t1   = dispatch_src1_tag;
          m_new.v2   = dispatch_src2_value;
          m_new.r2   = dispatch_src2_ready;
          m_new.t2   = dispatch_src2_tag;
          m_new.dest = dispatch_dest_tag;
          mq.push_back(m_wake(m_new));
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (started) begin
      c_k  = m_oldest();
      c_iv = (c_k >= 0) && !flush;
      check("m_issue_valid", 32'(issue_valid), 32'(c_iv));
      check("m_rs_count", 32'(rs_count), 32'(mq.size()));
      check("m_dispatch_ready", 32'(dispatch_ready), 32'(mq.size() < 8));
      if (c_iv) begin
        check("m_issue_op", 32'(issue_op), 32'(mq[c_k].op));
        check("m_issue_src1", issue_src1_value, mq[c_k].v1);
        check("m_issue_src2", issue_src2_value, mq[c_k].v2);
        check("m_issue_dest", 32'(issue_dest_tag), 32'(mq[c_k].dest));
      end
`ifdef RS_PERF_CNT_EN
      check("m_perf_issue", perf_issue_cnt, m_issues);
      check("m_perf_stall", perf_stall_cnt, m_stalls);
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    flush               = 1'b0;
    dispatch_valid      = 1'b0;
    dispatch_op         = '0;
    dispatch_src1_value = '0;
    dispatch_src2_value = '0;
    dispatch_src1_ready = 1'b0;
    dispatch_src2_ready = 1'b0;
    dispatch_src1_tag   = '0;
    dispatch_src2_tag   = '0;
    dispatch_dest_tag   = '0;
    cdb_valid           = '0;
    cdb_tag             = '0;
    cdb_data            = '0;
    issue_ready         = 1'b0;
  endtask

  task automatic set_disp(input logic [3:0] op, input logic [31:0] v1, input logic r1,
                          input logic [3:0] t1, input logic [31:0] v2, input logic r2,
                          input logic [3:0] t2, input logic [3:0] dest);
    dispatch_valid      = 1'b1;
    dispatch_op         = op;
    dispatch_src1_value = v1;
    dispatch_src1_ready = r1;
    dispatch_src1_tag   = t1;
    dispatch_src2_value = v2;
    dispatch_src2_ready = r2;
    dispatch_src2_tag   = t2;
    dispatch_dest_tag   = dest;
  endtask

  initial begin
    clr_in();
    reset = 1'b1;
    @(posedge clock);
    #1;
    started = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("reset_count", 32'(rs_count), 32'd0);
    check("reset_issue_valid", 32'(issue_valid), 32'd0);
    check("reset_dispatch_ready", 32'(dispatch_ready), 32'd1);

    // Single ready instruction issues the cycle after dispatch
    issue_ready = 1'b1;
    set_disp(4'd3, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'd1);
    tick();
    dispatch_valid = 1'b0;
    check("basic_issue_valid", 32'(issue_valid), 32'd1);
    check("basic_op", 32'(issue_op), 32'd3);
    check("basic_src1", issue_src1_value, 32'd5);
    check("basic_src2", issue_src2_value, 32'd7);
    tick();
    check("basic_count_after", 32'(rs_count), 32'd0);
    issue_ready = 1'b0;

    // Younger ready instruction bypasses older waiting one
    set_disp(4'd1, 32'd0, 1'b0, 4'd2, 32'h22, 1'b1, 4'd0, 4'd3);
    tick();
    set_disp(4'd2, 32'h10, 1'b1, 4'd0, 32'h11, 1'b1, 4'd0, 4'd4);
    tick();
    dispatch_valid = 1'b0;
    check("ooo_first_dest", 32'(issue_dest_tag), 32'd4);
    check("ooo_count", 32'(rs_count), 32'd2);
    cdb_valid   = 2'b01;
    cdb_tag[0]  = 4'd2;
    cdb_data[0] = 32'h99;
    issue_ready = 1'b1;
    tick();
    cdb_valid = '0;
    check("ooo_second_valid", 32'(issue_valid), 32'd1);
    check("ooo_second_dest", 32'(issue_dest_tag), 32'd3);
    check("ooo_wake_src1", issue_src1_value, 32'h99);
    tick();
    check("ooo_count_after", 32'(rs_count), 32'd0);
    issue_ready = 1'b0;

    // Dispatch-cycle bypass from port 1, then lowest-port priority
    cdb_valid   = 2'b11;
    cdb_tag[0]  = 4'd5;
    cdb_data[0] = 32'hdead;
    cdb_tag[1]  = 4'd6;
    cdb_data[1] = 32'h1234;
    set_disp(4'd5, 32'hA, 1'b1, 4'd0, 32'd0, 1'b0, 4'd6, 4'd5);
    tick();
    dispatch_valid = 1'b0;
    cdb_valid      = '0;
    check("bypass_valid", 32'(issue_valid), 32'd1);
    check("bypass_src2", issue_src2_value, 32'h1234);
    check("bypass_src1", issue_src1_value, 32'hA);
    cdb_valid   = 2'b11;
    cdb_tag[0]  = 4'd7;
    cdb_data[0] = 32'hAAAA;
    cdb_tag[1]  = 4'd7;
    cdb_data[1] = 32'hBBBB;
    set_disp(4'd6, 32'd0, 1'b0, 4'd7, 32'h66, 1'b1, 4'd0, 4'd6);
    tick();
    dispatch_valid = 1'b0;
    cdb_valid      = '0;
    issue_ready    = 1'b1;
    tick();
    check("prio_dest", 32'(issue_dest_tag), 32'd6);
    check("prio_src1", issue_src1_value, 32'hAAAA);
    tick();
    check("prio_count_after", 32'(rs_count), 32'd0);
    issue_ready = 1'b0;

    // Fill all slots with waiting instructions and stall further dispatch
    for (int i = 0; i < 8; i++) begin
      set_disp(4'(i), 32'(i), 1'b0, 4'd9, 32'h100 + 32'(i), 1'b1, 4'd0, 4'(i));
      tick();
    end
    set_disp(4'd8, 32'd8, 1'b1, 4'd0, 32'h108, 1'b1, 4'd0, 4'd8);
    check("full_count", 32'(rs_count), 32'd8);
    check("full_dispatch_ready", 32'(dispatch_ready), 32'd0);
    check("full_issue_valid", 32'(issue_valid), 32'd0);
    tick();
    tick();
    tick();
`ifdef RS_PERF_CNT_EN
    check("full_stall_cnt", perf_stall_cnt, 32'd3);
`endif
    cdb_valid   = 2'b01;
    cdb_tag[0]  = 4'd9;
    cdb_data[0] = 32'h55;
    tick();
    cdb_valid = '0;
    check("full_wake_dest", 32'(issue_dest_tag), 32'd0);
    check("full_wake_src1", issue_src1_value, 32'h55);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("free_dispatch_ready", 32'(dispatch_ready), 32'd1);
    check("free_count", 32'(rs_count), 32'd7);
`ifdef RS_PERF_CNT_EN
    check("free_stall_cnt", perf_stall_cnt, 32'd5);
    check("free_issue_cnt", perf_issue_cnt, 32'd6);
`endif
    tick();
    dispatch_valid = 1'b0;
    check("refill_count", 32'(rs_count), 32'd8);
    issue_ready = 1'b1;
    repeat (8) tick();
    check("drain_count", 32'(rs_count), 32'd0);
    issue_ready = 1'b0;

    // Flush with a concurrent dispatch kills issue and empties the station
    set_disp(4'd1, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd1);
    tick();
    set_disp(4'd2, 32'd3, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 4'd2);
    tick();
    dispatch_valid = 1'b0;
    check("preflush_valid", 32'(issue_valid), 32'd1);
    check("preflush_count", 32'(rs_count), 32'd2);
    flush = 1'b1;
    set_disp(4'd3, 32'd5, 1'b1, 4'd0, 32'd6, 1'b1, 4'd0, 4'd3);
    #1;
    check("flush_issue_valid", 32'(issue_valid), 32'd0);
    tick();
    flush          = 1'b0;
    dispatch_valid = 1'b0;
    check("flush_count", 32'(rs_count), 32'd0);
    check("flush_issue_after", 32'(issue_valid), 32'd0);

    // Reused slot 0 must still issue after the older slots 1-3
    set_disp(4'd0, 32'd0, 1'b0, 4'd10, 32'd1, 1'b1, 4'd0, 4'd10);
    tick();
    for (int k = 1; k < 4; k++) begin
      set_disp(4'(k), 32'd0, 1'b0, 4'd11, 32'(k), 1'b1, 4'd0, 4'(10 + k));
      tick();
    end
    dispatch_valid = 1'b0;
    check("age_count4", 32'(rs_count), 32'd4);
    check("age_none_ready", 32'(issue_valid), 32'd0);
    cdb_valid   = 2'b01;
    cdb_tag[0]  = 4'd10;
    cdb_data[0] = 32'h77;
    tick();
    cdb_valid = '0;
    check("age_slot0_dest", 32'(issue_dest_tag), 32'd10);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("age_count3", 32'(rs_count), 32'd3);
    set_disp(4'hD, 32'hD0, 1'b1, 4'd0, 32'hD1, 1'b1, 4'd0, 4'd15);
    cdb_valid   = 2'b01;
    cdb_tag[0]  = 4'd11;
    cdb_data[0] = 32'h11;
    tick();
    dispatch_valid = 1'b0;
    cdb_valid      = '0;
    check("age_first_dest", 32'(issue_dest_tag), 32'd11);
    issue_ready = 1'b1;
    tick();
    check("age_second_dest", 32'(issue_dest_tag), 32'd12);
    tick();
    check("age_third_dest", 32'(issue_dest_tag), 32'd13);
    tick();
    check("age_d_dest", 32'(issue_dest_tag), 32'd15);
    tick();
    check("age_count_after", 32'(rs_count), 32'd0);
    issue_ready = 1'b0;

    // Reset in the middle of traffic wins over dispatch and issue
    set_disp(4'd4, 32'd4, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 4'd4);
    tick();
    reset       = 1'b1;
    issue_ready = 1'b1;
    set_disp(4'd5, 32'd5, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 4'd5);
    tick();
    reset          = 1'b0;
    dispatch_valid = 1'b0;
    issue_ready    = 1'b0;
    check("rst2_count", 32'(rs_count), 32'd0);
    check("rst2_issue_valid", 32'(issue_valid), 32'd0);
    check("rst2_dispatch_ready", 32'(dispatch_ready), 32'd1);
`ifdef RS_PERF_CNT_EN
    check("rst2_issue_cnt", perf_issue_cnt, 32'd0);
    check("rst2_stall_cnt", perf_stall_cnt, 32'd0);
`endif
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
